// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter for the shared address/data bus with an address-phase timeout.
// Optional saturating error counter is enabled by defining ARB_ERR_CNT_EN.
module bus_rr_arbiter #(
   parameter int DEVICE_MAX_NUMBER = 4,
   parameter int CLK_MAX_TIMEOUT   = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DEVICE_MAX_NUMBER-1:0] barq_i,
   output logic [DEVICE_MAX_NUMBER-1:0] bagd_o,
   output logic                         target_ready_o,
   input  logic                         address_valid_i,
   output logic                         data_strobe_o,
   output logic                         error_o,
   output logic                         busy_o
`ifdef ARB_ERR_CNT_EN
   ,
   input  logic                         err_clr_i,
   output logic [7:0]                   err_count_o
`endif
);

   localparam int PW = (DEVICE_MAX_NUMBER > 1) ? $clog2(DEVICE_MAX_NUMBER) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ADDR    = 3'd1,
      S_DATA    = 3'd2,
      S_RELEASE = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   state_t                       r_state;
   state_t                       w_state_nxt;
   logic [DEVICE_MAX_NUMBER-1:0] r_bagd;
   logic [DEVICE_MAX_NUMBER-1:0] w_bagd_nxt;
   logic [PW-1:0]                r_ptr;
   logic [PW-1:0]                w_ptr_nxt;
   logic [7:0]                   r_cnt;
   logic [7:0]                   w_cnt_nxt;
   logic                         r_tready;
   logic                         r_strobe;
   logic                         r_error;
   logic                         r_busy;
   logic [PW-1:0]                w_sel_idx;
   logic                         w_sel_vld;
   logic [PW:0]                  w_sum;
   logic [PW:0]                  w_idx;
   logic [DEVICE_MAX_NUMBER-1:0] w_onehot;

   // Search upward from pointer+1; iterating downward lets the nearest requester win last.
   always_comb begin
      w_sel_idx = r_ptr;
      w_sel_vld = 1'b0;
      w_sum     = '0;
      w_idx     = '0;
      for (int i = DEVICE_MAX_NUMBER; i >= 1; i--) begin
         w_sum     = {1'b0, r_ptr} + (PW+1)'(i);
         w_idx     = (w_sum >= (PW+1)'(DEVICE_MAX_NUMBER)) ?
                     (w_sum - (PW+1)'(DEVICE_MAX_NUMBER)) : w_sum;
         w_sel_vld = w_sel_vld | barq_i[w_idx[PW-1:0]];
         w_sel_idx = barq_i[w_idx[PW-1:0]] ? w_idx[PW-1:0] : w_sel_idx;
      end
      w_onehot = {{(DEVICE_MAX_NUMBER-1){1'b0}}, 1'b1} << w_sel_idx;
   end

   // Next-state, grant, pointer and timeout counter.
   always_comb begin
      w_state_nxt = r_state;
      w_bagd_nxt  = r_bagd;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_sel_vld) begin
               w_state_nxt = S_ADDR;
               w_bagd_nxt  = w_onehot;
               w_ptr_nxt   = w_sel_idx;
               w_cnt_nxt   = 8'd1;
            end else begin
               w_state_nxt = S_IDLE;
               w_bagd_nxt  = '0;
               w_cnt_nxt   = 8'd0;
            end
         end
         S_ADDR: begin
            if ((barq_i & r_bagd) == '0) begin
               w_state_nxt = S_RELEASE;
               w_bagd_nxt  = '0;
               w_cnt_nxt   = 8'd0;
            end else if (address_valid_i) begin
               w_state_nxt = S_DATA;
            end else if (r_cnt == 8'(CLK_MAX_TIMEOUT)) begin
               w_state_nxt = S_ERROR;
               w_bagd_nxt  = '0;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_cnt_nxt   = r_cnt + 8'd1;
            end
         end
         S_DATA: begin
            w_state_nxt = S_RELEASE;
            w_bagd_nxt  = '0;
            w_cnt_nxt   = 8'd0;
         end
         S_RELEASE: begin
            w_state_nxt = S_IDLE;
            w_bagd_nxt  = '0;
            w_cnt_nxt   = 8'd0;
         end
         S_ERROR: begin
            w_state_nxt = S_IDLE;
            w_bagd_nxt  = '0;
            w_cnt_nxt   = 8'd0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_bagd_nxt  = '0;
            w_cnt_nxt   = 8'd0;
         end
      endcase
   end

   // State register; outputs are registered copies decoded from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_bagd   <= '0;
         r_ptr    <= PW'(DEVICE_MAX_NUMBER - 1);
         r_cnt    <= 8'd0;
         r_tready <= 1'b0;
         r_strobe <= 1'b0;
         r_error  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_bagd   <= w_bagd_nxt;
         r_ptr    <= w_ptr_nxt;
         r_cnt    <= w_cnt_nxt;
         r_tready <= (w_state_nxt == S_ADDR) || (w_state_nxt == S_DATA);
         r_strobe <= (w_state_nxt == S_DATA);
         r_error  <= (w_state_nxt == S_ERROR);
         r_busy   <= (w_state_nxt != S_IDLE);
      end
   end

   assign bagd_o         = r_bagd;
   assign target_ready_o = r_tready;
   assign data_strobe_o  = r_strobe;
   assign error_o        = r_error;
   assign busy_o         = r_busy;

`ifdef ARB_ERR_CNT_EN
   logic [7:0] r_err_cnt;

   // Saturating count of timeouts; clear beats increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= 8'd0;
      end else if (err_clr_i) begin
         r_err_cnt <= 8'd0;
      end else if ((w_state_nxt == S_ERROR) && (r_state == S_ADDR) && (r_err_cnt != 8'd255)) begin
         r_err_cnt <= r_err_cnt + 8'd1;
      end else begin
         r_err_cnt <= r_err_cnt;
      end
   end

   assign err_count_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench for bus_rr_arbiter: vector table, directed corner sequences,
// and randomized transactions checked against a transaction-level round-robin model.
module tb_bus_rr_arbiter;

   localparam int N = 4;
   localparam int T = 10;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] barq_i;
   logic [N-1:0] bagd_o;
   logic         target_ready_o;
   logic         address_valid_i;
   logic         data_strobe_o;
   logic         error_o;
   logic         busy_o;
`ifdef ARB_ERR_CNT_EN
   logic         err_clr_i;
   logic [7:0]   err_count_o;
   int           exp_errcnt;
`endif

   int n_cmp;
   int n_bad;
   int ptr_m;

   bus_rr_arbiter #(.DEVICE_MAX_NUMBER(N), .CLK_MAX_TIMEOUT(T)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .barq_i         (barq_i),
      .bagd_o         (bagd_o),
      .target_ready_o (target_ready_o),
      .address_valid_i(address_valid_i),
      .data_strobe_o  (data_strobe_o),
      .error_o        (error_o),
      .busy_o         (busy_o)
`ifdef ARB_ERR_CNT_EN
      ,
      .err_clr_i      (err_clr_i),
      .err_count_o    (err_count_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] barq;
      logic         av;
      logic [N-1:0] bagd;
      logic         tr;
      logic         ds;
      logic         err;
      logic         busy;
   } vec_t;

   vec_t tbl [12];

   function automatic int rr_pick(input int ptr, input logic [N-1:0] req);
      for (int k = 1; k <= N; k++) begin
         if (req[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [N-1:0] eb, input logic etr,
                        input logic eds, input logic eerr, input logic ebusy);
      n_cmp++;
      if (bagd_o !== eb || target_ready_o !== etr || data_strobe_o !== eds ||
          error_o !== eerr || busy_o !== ebusy) begin
         n_bad++;
         $display("FAIL %s: got bagd=%b tr=%b ds=%b err=%b busy=%b, want bagd=%b tr=%b ds=%b err=%b busy=%b",
                  name, bagd_o, target_ready_o, data_strobe_o, error_o, busy_o,
                  eb, etr, eds, eerr, ebusy);
      end
   endtask

   task automatic note_error();
`ifdef ARB_ERR_CNT_EN
      if (exp_errcnt < 255) exp_errcnt++;
`endif
   endtask

   task automatic check_errcnt(input string name);
`ifdef ARB_ERR_CNT_EN
      n_cmp++;
      if (err_count_o !== 8'(exp_errcnt)) begin
         n_bad++;
         $display("FAIL %s: got err_count=%0d, want %0d", name, err_count_o, exp_errcnt);
      end
`else
      if (name.len() == 0) $display("errcnt check skipped");
`endif
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      barq_i          = '0;
      address_valid_i = 1'b0;
`ifdef ARB_ERR_CNT_EN
      err_clr_i       = 1'b0;
      exp_errcnt      = 0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      check_errcnt("reset_errcnt");
      rst_n = 1'b1;
      ptr_m = N - 1;
   endtask

   initial begin
      int           g;
      int           w;
      int           a;
      int           outcome;
      logic [N-1:0] gh;
      logic [N-1:0] junk;
      logic [N-1:0] req;

      n_cmp = 0;
      n_bad = 0;

      // single request with two wait cycles, then abort of a grant to master 2
      tbl[0]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[3]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{4'b1110, 1'b0, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{4'b1011, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 12; i++) begin
         barq_i          = tbl[i].barq;
         address_valid_i = tbl[i].av;
         step();
         check($sformatf("vec%0d", i), tbl[i].bagd, tbl[i].tr, tbl[i].ds, tbl[i].err, tbl[i].busy);
      end

      // fairness: all requests held, address_valid immediate
      do_reset();
      for (int t = 0; t < 8; t++) begin
         barq_i = 4'b1111; address_valid_i = 1'b0;
         step();
         g = rr_pick(ptr_m, 4'b1111); ptr_m = g; gh = 4'b0001 << g;
         check($sformatf("rot_grant%0d", t), gh, 1'b1, 1'b0, 1'b0, 1'b1);
         if (gh !== (4'b0001 << (t % N))) begin
            n_bad++;
            $display("FAIL rot_model%0d: model gives %b, want %b", t, gh, 4'b0001 << (t % N));
         end
         address_valid_i = 1'b1;
         step();
         check($sformatf("rot_data%0d", t), gh, 1'b1, 1'b1, 1'b0, 1'b1);
         address_valid_i = 1'b0;
         step();
         check($sformatf("rot_rel%0d", t), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
         step();
         check($sformatf("rot_idle%0d", t), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // timeout with no slave response
      barq_i = 4'b0010; address_valid_i = 1'b0;
      step();
      check("to_grant", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int j = 1; j <= T; j++) begin
         step();
         if (j < T) check($sformatf("to_addr%0d", j), 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
         else       check("to_error", 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
      end
      note_error();
      ptr_m = 1;
      step();
      check("to_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      check_errcnt("to_errcnt");

      // address_valid on the same edge the timeout would fire
      barq_i = 4'b0001;
      step();
      check("sim_grant", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int j = 1; j < T; j++) step();
      check("sim_addr10", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
      address_valid_i = 1'b1;
      step();
      check("sim_data", 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1);
      address_valid_i = 1'b0;
      step();
      check("sim_rel", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
      check("sim_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // asynchronous reset in the middle of the data phase
      barq_i = 4'b0100;
      step();
      check("rst_grant", 4'b0100, 1'b1, 1'b0, 1'b0, 1'b1);
      address_valid_i = 1'b1;
      step();
      check("rst_data", 4'b0100, 1'b1, 1'b1, 1'b0, 1'b1);
      rst_n = 1'b0;
      #2;
      check("rst_async", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ARB_ERR_CNT_EN
      exp_errcnt = 0;
`endif
      #2;
      rst_n = 1'b1; barq_i = 4'b1111; address_valid_i = 1'b0;
      step();
      check("rst_first", 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
      ptr_m = 0;
      address_valid_i = 1'b1;
      step();
      check("rst_data2", 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1);
      address_valid_i = 1'b0;
      step();
      step();
      check("rst_idle", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // randomized transactions against the round-robin model
      for (int t = 0; t < 40; t++) begin
         req = 4'($urandom_range(1, 15));
         barq_i = req; address_valid_i = 1'($urandom_range(0, 1));
         step();
         g = rr_pick(ptr_m, req); ptr_m = g; gh = 4'b0001 << g;
         check($sformatf("rnd%0d_grant", t), gh, 1'b1, 1'b0, 1'b0, 1'b1);
         w = $urandom_range(0, 11);
         a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, T) : 0;
         outcome = 0;
         for (int j = 1; j <= T && outcome == 0; j++) begin
            junk = 4'($urandom);
            barq_i = (j == a) ? (junk & ~gh) : (junk | gh);
            address_valid_i = (j == w + 1);
            step();
            if (j == a) begin
               outcome = 3;
               check($sformatf("rnd%0d_abort", t), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
            end else if (j == w + 1) begin
               outcome = 1;
               check($sformatf("rnd%0d_data", t), gh, 1'b1, 1'b1, 1'b0, 1'b1);
            end else if (j == T) begin
               outcome = 2;
               note_error();
               check($sformatf("rnd%0d_error", t), 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
            end else begin
               check($sformatf("rnd%0d_addr%0d", t, j), gh, 1'b1, 1'b0, 1'b0, 1'b1);
            end
         end
         if (outcome == 1) begin
            barq_i = 4'($urandom); address_valid_i = 1'($urandom_range(0, 1));
            step();
            check($sformatf("rnd%0d_rel", t), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
         end
         barq_i = 4'($urandom); address_valid_i = 1'($urandom_range(0, 1));
         step();
         check($sformatf("rnd%0d_idle", t), 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      check_errcnt("rnd_errcnt");

`ifdef ARB_ERR_CNT_EN
      err_clr_i = 1'b1;
      step();
      err_clr_i = 1'b0;
      exp_errcnt = 0;
      check_errcnt("clr_errcnt");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_rr_arbiter.md
Name: bus_rr_arbiter

Overview:
- Round-robin arbiter for the shared 16-bit address/data bus.
- Masters request with barq_i and get a one-hot grant on bagd_o. The grant drives the master-select mux of the bus.
- Each bus cycle runs in fixed phases: address phase (target_ready_o high), wait for the slave's address_valid_i, one-cycle data_strobe_o, then release.
- Missing slave response causes a timeout and raises error_o.

Parameters:
- DEVICE_MAX_NUMBER, 4: number of bus masters (2..16).
- CLK_MAX_TIMEOUT, 10: max address-phase cycles waiting for address_valid_i before error (1..255).

Ports:
- clk  in  1  bus clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- barq_i  in  DEVICE_MAX_NUMBER  per-master bus request, level; held until grant seen.
- bagd_o  out  DEVICE_MAX_NUMBER  one-hot bus grant, registered.
- target_ready_o  out  1  address phase active; low clears slave dev_sel (async).
- address_valid_i  in  1  OR of registered slave selects; some slave decoded the address.
- data_strobe_o  out  1  one-cycle write/read strobe.
- error_o  out  1  one-cycle pulse on timeout.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE.
  - bagd_o=0, target_ready_o=0, data_strobe_o=0, error_o=0, busy_o=0.
  - Timeout counter=0; round-robin pointer=DEVICE_MAX_NUMBER-1, so master 0 wins first.
- States: IDLE, ADDR, DATA, RELEASE, ERROR. All outputs registered, decoded from the state register.
- IDLE:
  - If barq_i != 0, select the first set bit searching upward from pointer+1 modulo DEVICE_MAX_NUMBER.
  - Load bagd_o with that one-hot, set the pointer to that index, go to ADDR.
  - Latency: barq_i sampled high at edge k -> bagd_o and target_ready_o high after edge k.
- ADDR:
  - bagd_o held, target_ready_o=1, counter increments each cycle starting at 1.
  - Priority order, evaluated each edge:
    - (a) Granted master's barq bit low -> RELEASE (abort; no strobe, no error).
    - (b) address_valid_i=1 -> DATA.
    - (c) Counter == CLK_MAX_TIMEOUT -> ERROR.
  - address_valid_i and timeout on the same edge: (b) wins.
- DATA:
  - data_strobe_o=1 for exactly one cycle; bagd_o and target_ready_o still high.
  - Always goes to RELEASE.
- RELEASE:
  - bagd_o=0, target_ready_o=0 for exactly one cycle, forcing all dev_sel low.
  - Counter cleared, then IDLE.
  - Minimum gap between grants is one idle cycle, so back-to-back transactions occupy 4+W cycles each (W = wait cycles before address_valid_i).
- ERROR:
  - error_o=1 one cycle, bagd_o=0, target_ready_o=0, counter cleared, then IDLE.
  - Pointer keeps the failed master's index, so the failed master gets lowest priority next round.
- Fairness: with all requests held, grants rotate 0,1,2,3,0…; no master waits more than DEVICE_MAX_NUMBER-1 transactions.
- Requests arriving while not IDLE are ignored until IDLE; barq_i changes outside IDLE (except the abort in ADDR) have no effect.
- address_valid_i outside ADDR is ignored.
- bagd_o is never multi-hot; data_strobe_o never coincides with error_o.
- Reset mid-transaction: all outputs drop asynchronously; no strobe is emitted afterwards.

Optional Feature:
- Macro ARB_ERR_CNT_EN.
- Defined:
  - Adds port err_count_o, out, 8 bits: saturating count of ERROR entries.
  - Reset 0; increments on the edge entering ERROR; holds at 255.
  - Adds input err_clr_i, 1 bit: synchronous clear, which wins over increment on the same edge.
- Undefined: neither port exists; no counter logic.

Test Plan (DEVICE_MAX_NUMBER=4, CLK_MAX_TIMEOUT=10):
- barq_i=4'b0001, address_valid_i raised 2 cycles after grant:
  - bagd_o=0001 one cycle after request.
  - data_strobe_o single pulse the cycle after address_valid_i.
  - target_ready_o low exactly 1 cycle in RELEASE.
- barq_i=4'b1111 held for 8 transactions, address_valid_i immediate → grant order 0001,0010,0100,1000,0001,0010,0100,1000.
- barq_i=4'b0010, address_valid_i never asserted:
  - error_o pulses one cycle, 10 cycles after grant.
  - No data_strobe_o; bagd_o=0 on the error cycle.
  - With ARB_ERR_CNT_EN, err_count_o=1.
- Grant to master 2, barq_i[2] dropped on cycle 3 of ADDR → RELEASE, no strobe, no error_o, back to IDLE.
- address_valid_i rises on the same edge the counter reaches 10 → DATA taken, data_strobe_o=1, error_o=0.
- rst_n pulsed low during DATA → data_strobe_o, bagd_o, target_ready_o immediately 0; after release, master 0 is granted first.
